// File: rtl/div_pkg.sv
// Shared types and helpers for the restoring divider sequencer.
package div_pkg;

    // Controller states: waiting for work, iterating, presenting the result.
    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Width of the iteration counter, which must hold WL-1.
    function automatic int CNT_W(input int wl);
        return (wl <= 2) ? 1 : $clog2(wl);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, then compare-subtract against the divisor.
module div_step #(
    parameter int WL = 4
) (
    input  logic [WL:0]   rh_i,
    input  logic          n_bit_i,
    input  logic [WL-1:0] d_i,
    output logic [WL:0]   rh_o,
    output logic          q_bit_o
);

    localparam int RW = WL + 1;

    // The partial remainder entering a step is always below 2^WL, so its top
    // bit is zero and shifting the whole register matches shifting its low WL
    // bits; the extra bit keeps the compare exact without dropping anything.
    logic [WL+1:0] rh_s;
    logic [WL+1:0] d_ext;

    // Shift in the dividend bit, then subtract the divisor if it fits.
    always_comb begin
        // NOTE: every output gets a value before any branch, so no path leaves
        // a signal unassigned and no latch is inferred.
        rh_s    = {rh_i, n_bit_i};
        d_ext   = {2'b00, d_i};
        rh_o    = RW'(rh_s);
        q_bit_o = 1'b0;
        if (rh_s >= d_ext) begin
            rh_o    = RW'(rh_s - d_ext);
            q_bit_o = 1'b1;
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Sequential controller for a restoring unsigned divider: accepts n/d on
// start, runs WL shift/compare-subtract steps MSB first, then pulses done
// and holds q, r and dbz until the next accepted start.
// Optional feature macro: DIV_BY_ZERO_DETECT_EN (short-circuits d=0 to DONE
// in one cycle and raises dbz).
module div_sequencer
    import div_pkg::*;
#(
    parameter int WL = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [WL-1:0] n,
    input  logic [WL-1:0] d,
    output logic          busy,
    output logic          done,
    output logic [WL-1:0] q,
    output logic [WL-1:0] r,
    output logic          dbz
);

    localparam int CW = CNT_W(WL);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [WL:0]   rh_q,    rh_d;
    logic [WL-1:0] q_q,     q_d;
    logic [WL-1:0] n_q,     n_d;
    logic [WL-1:0] d_q,     d_d;
    logic [WL:0]   step_rh;
    logic          step_q;
`ifdef DIV_BY_ZERO_DETECT_EN
    logic          dbz_q,   dbz_d;
`endif

    div_step #(
        .WL(WL)
    ) u_step (
        .rh_i    (rh_q),
        .n_bit_i (n_q[count_q]),
        .d_i     (d_q),
        .rh_o    (step_rh),
        .q_bit_o (step_q)
    );

    // Next-state, counter and datapath register updates.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rh_d    = rh_q;
        q_d     = q_q;
        n_d     = n_q;
        d_d     = d_q;
`ifdef DIV_BY_ZERO_DETECT_EN
        dbz_d   = dbz_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    n_d     = n;
                    d_d     = d;
                    rh_d    = '0;
                    q_d     = '0;
                    count_d = CW'(WL - 1);
                    state_d = RUN;
`ifdef DIV_BY_ZERO_DETECT_EN
                    dbz_d   = 1'b0;
                    // Same q/r the full algorithm would give, without the wait.
                    if (d == '0) begin
                        dbz_d   = 1'b1;
                        q_d     = '1;
                        rh_d    = {1'b0, n};
                        state_d = DONE;
                    end
`endif
                end
            end
            RUN: begin
                rh_d         = step_rh;
                q_d[count_q] = step_q;
                if (count_q == '0) begin
                    state_d = DONE;
                end else begin
                    count_d = count_q - CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: registers are written with non-blocking assignments so every
        // flop samples the pre-edge values, independent of statement order.
        if (rst) begin
            state_q <= IDLE;
            count_q <= '0;
            rh_q    <= '0;
            q_q     <= '0;
            n_q     <= '0;
            d_q     <= '0;
`ifdef DIV_BY_ZERO_DETECT_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rh_q    <= rh_d;
            q_q     <= q_d;
            n_q     <= n_d;
            d_q     <= d_d;
`ifdef DIV_BY_ZERO_DETECT_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign q    = q_q;
    assign r    = rh_q[WL-1:0];
`ifdef DIV_BY_ZERO_DETECT_EN
    assign dbz  = dbz_q;
`else
    assign dbz  = 1'b0;
`endif

endmodule
